// File: rtl/vec_reg_file_if.sv
// Bus bundle for vec_reg_file: parallel write, two read ports, stream load/store and status.
// The slave modport is the register file; the master modport is the host / vector ALU side.
interface vec_reg_file_if #(
  parameter int BITS  = 8,
  parameter int N     = 64,
  parameter int NREGS = 16,
  parameter int LEN_W = $clog2(N + 1),
  parameter int SEL_W = $clog2(NREGS)
);
  logic                       wr_en;
  logic [SEL_W-1:0]           wr_sel;
  logic [N-1:0][BITS-1:0]     wr_data;
  logic [LEN_W-1:0]           wr_len;
  logic                       rd_en_a, rd_en_b;
  logic [SEL_W-1:0]           rd_sel_a, rd_sel_b;
  logic [N-1:0][BITS-1:0]     out_a, out_b;
  logic [LEN_W-1:0]           out_a_len, out_b_len;
  logic                       out_a_vld, out_b_vld;
  logic                       ld_start, st_start;
  logic [SEL_W-1:0]           st_sel;
  logic [LEN_W-1:0]           ld_len;
  logic [BITS-1:0]            s_data;
  logic                       s_valid, s_ready;
  logic [BITS-1:0]            m_data;
  logic                       m_valid, m_ready, m_last;
  logic                       busy, wr_err;

  modport slave (
    input  wr_en, wr_sel, wr_data, wr_len,
    input  rd_en_a, rd_en_b, rd_sel_a, rd_sel_b,
    output out_a, out_b, out_a_len, out_b_len, out_a_vld, out_b_vld,
    input  ld_start, st_start, st_sel, ld_len,
    input  s_data, s_valid,
    output s_ready,
    output m_data, m_valid, m_last,
    input  m_ready,
    output busy, wr_err
  );

  modport master (
    output wr_en, wr_sel, wr_data, wr_len,
    output rd_en_a, rd_en_b, rd_sel_a, rd_sel_b,
    input  out_a, out_b, out_a_len, out_b_len, out_a_vld, out_b_vld,
    output ld_start, st_start, st_sel, ld_len,
    output s_data, s_valid,
    input  s_ready,
    input  m_data, m_valid, m_last,
    output m_ready,
    input  busy, wr_err
  );
endinterface

// File: rtl/vec_reg_file.sv
// Clocked vector register file: 1-cycle parallel write, two registered read ports (latency 1),
// plus a valid/ready element stream that loads or stores one register while locking it.
module vec_reg_file #(
  parameter int BITS  = 8,
  parameter int N     = 64,
  parameter int NREGS = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  vec_reg_file_if.slave  bus
);
  localparam int LEN_W = $clog2(N + 1);
  localparam int SEL_W = $clog2(NREGS);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(N);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef logic [N-1:0][BITS-1:0] vec_t;
  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > LEN_MAX) ? LEN_MAX : l;
  endfunction

  vec_t             mem_q [NREGS];
  logic [LEN_W-1:0] len_q [NREGS];
  logic [NREGS-1:0] vld_q;
  logic             wr_err_q;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] tgt_q, tgt_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] tlen_q, tlen_d;
  logic             ld_init, ld_empty, ld_beat, ld_done;

  logic [IDX_W-1:0] cnt_idx;
  logic [LEN_W-1:0] ld_len_c;
  logic             wr_locked;

  assign cnt_idx   = cnt_q[IDX_W-1:0];
  assign ld_len_c  = clamp_len(bus.ld_len);
  assign wr_locked = (state_q != IDLE) && (bus.wr_sel == tgt_q);

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    cnt_d    = cnt_q;
    tlen_d   = tlen_q;
    ld_init  = 1'b0;
    ld_empty = 1'b0;
    ld_beat  = 1'b0;
    ld_done  = 1'b0;
    case (state_q)
      IDLE: begin
        // Load has priority over a simultaneous store request.
        if (bus.ld_start) begin
          tgt_d   = bus.st_sel;
          cnt_d   = '0;
          tlen_d  = ld_len_c;
          ld_init = 1'b1;
          if (ld_len_c == '0) ld_empty = 1'b1;
          else                state_d  = LOAD;
        end else if (bus.st_start) begin
          tgt_d = bus.st_sel;
          cnt_d = '0;
          if (len_q[bus.st_sel] != '0) state_d = STORE;
        end
      end
      LOAD: begin
        if (bus.s_valid) begin
          ld_beat = 1'b1;
          if (cnt_q == tlen_q - LEN_ONE) begin
            ld_done = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + LEN_ONE;
          end
        end
      end
      STORE: begin
        if (bus.m_ready) begin
          if (cnt_q == len_q[tgt_q] - LEN_ONE) state_d = IDLE;
          else                                 cnt_d   = cnt_q + LEN_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      cnt_q   <= '0;
      tlen_q  <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      tlen_q  <= tlen_d;
    end
  end

  // Storage: later statements override earlier ones, so a load start wins over a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
        len_q[r] <= '0;
      end
      vld_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      if (bus.wr_en) begin
        if (wr_locked) begin
          wr_err_q <= 1'b1;
        end else begin
          mem_q[bus.wr_sel] <= bus.wr_data;
          len_q[bus.wr_sel] <= clamp_len(bus.wr_len);
          vld_q[bus.wr_sel] <= 1'b1;
        end
      end
      if (ld_init) begin
        mem_q[bus.st_sel] <= '0;
        vld_q[bus.st_sel] <= ld_empty;
        if (ld_empty) len_q[bus.st_sel] <= '0;
      end
      if (ld_beat) mem_q[tgt_q][cnt_idx] <= bus.s_data;
      if (ld_done) begin
        len_q[tgt_q] <= tlen_q;
        vld_q[tgt_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_a     <= '0;
      bus.out_a_len <= '0;
      bus.out_a_vld <= 1'b0;
      bus.out_b     <= '0;
      bus.out_b_len <= '0;
      bus.out_b_vld <= 1'b0;
    end else begin
      bus.out_a     <= bus.rd_en_a ? mem_q[bus.rd_sel_a] : '0;
      bus.out_a_len <= bus.rd_en_a ? len_q[bus.rd_sel_a] : '0;
      bus.out_a_vld <= bus.rd_en_a && vld_q[bus.rd_sel_a];
      bus.out_b     <= bus.rd_en_b ? mem_q[bus.rd_sel_b] : '0;
      bus.out_b_len <= bus.rd_en_b ? len_q[bus.rd_sel_b] : '0;
      bus.out_b_vld <= bus.rd_en_b && vld_q[bus.rd_sel_b];
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.s_ready = (state_q == LOAD);
  assign bus.m_valid = (state_q == STORE);
  assign bus.m_data  = (state_q == STORE) ? mem_q[tgt_q][cnt_idx] : '0;
  assign bus.m_last  = (state_q == STORE) && (cnt_q == len_q[tgt_q] - LEN_ONE);
  assign bus.wr_err  = wr_err_q;
endmodule

// File: tb/tb_vec_reg_file.sv
// Directed bench for vec_reg_file: parallel write/read, stream load/store, lock, length edges, async reset.
module tb_vec_reg_file;
  localparam int BITS  = 8;
  localparam int N     = 64;
  localparam int NREGS = 16;
  localparam int LEN_W = $clog2(N + 1);
  localparam int SEL_W = $clog2(NREGS);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vec_reg_file_if #(.BITS(BITS), .N(N), .NREGS(NREGS)) bus ();

  vec_reg_file #(.BITS(BITS), .N(N), .NREGS(NREGS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [N*BITS-1:0] act, input logic [N*BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [N-1:0][BITS-1:0] ev;
  int beats;
  int cyc;

  initial begin
    bus.wr_en = 0; bus.wr_sel = '0; bus.wr_data = '0; bus.wr_len = '0;
    bus.rd_en_a = 0; bus.rd_en_b = 0; bus.rd_sel_a = '0; bus.rd_sel_b = '0;
    bus.ld_start = 0; bus.st_start = 0; bus.st_sel = '0; bus.ld_len = '0;
    bus.s_data = '0; bus.s_valid = 0; bus.m_ready = 0;

    repeat (2) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_sready", bus.s_ready, 0);
    check("rst_mvalid", bus.m_valid, 0);
    check("rst_werr", bus.wr_err, 0);
    check("rst_outa_vld", bus.out_a_vld, 0);
    rst_n = 1'b1;
    tick();

    // Parallel write with same-cycle read of the same register
    for (int i = 0; i < N; i++) ev[i] = 8'(i + 1);
    bus.wr_en = 1; bus.wr_sel = 4'd3; bus.wr_data = ev; bus.wr_len = 7'd10;
    bus.rd_en_a = 1; bus.rd_sel_a = 4'd3;
    tick();
    bus.wr_en = 0;
    check("wr_rbw_vld", bus.out_a_vld, 0);
    check("wr_rbw_len", bus.out_a_len, 0);
    tick();
    check("wr_vld", bus.out_a_vld, 1);
    check("wr_len", bus.out_a_len, 10);
    check("wr_elem9", bus.out_a[9], 10);
    check("wr_data", bus.out_a, ev);
    bus.rd_en_a = 0;
    tick();
    check("rd_dis_data", bus.out_a, 0);
    check("rd_dis_vld", bus.out_a_vld, 0);

    // Stream load of reg5 with gaps between beats
    bus.ld_start = 1; bus.st_sel = 4'd5; bus.ld_len = 7'd4;
    tick();
    bus.ld_start = 0;
    check("ld_busy", bus.busy, 1);
    check("ld_sready", bus.s_ready, 1);
    for (int i = 0; i < 4; i++) begin
      bus.s_valid = 0;
      tick();
      check("ld_busy_mid", bus.busy, 1);
      bus.s_valid = 1; bus.s_data = 8'(8'hA1 + i);
      tick();
    end
    bus.s_valid = 0;
    check("ld_busy_fall", bus.busy, 0);
    check("ld_sready_fall", bus.s_ready, 0);
    bus.rd_en_a = 1; bus.rd_sel_a = 4'd5;
    tick();
    ev = '0;
    ev[0] = 8'hA1; ev[1] = 8'hA2; ev[2] = 8'hA3; ev[3] = 8'hA4;
    check("ld_data", bus.out_a, ev);
    check("ld_len", bus.out_a_len, 4);
    check("ld_vld", bus.out_a_vld, 1);

    // Stream store of reg5 with m_ready toggling 1/0
    bus.st_start = 1; bus.st_sel = 4'd5;
    tick();
    bus.st_start = 0;
    beats = 0; cyc = 0;
    while (beats < 4 && cyc < 20) begin
      bus.m_ready = (cyc % 2 == 0);
      check("st_mvalid", bus.m_valid, 1);
      check("st_mdata", bus.m_data, ev[beats]);
      check("st_mlast", bus.m_last, (beats == 3));
      if (bus.m_valid && bus.m_ready) beats++;
      tick();
      cyc++;
    end
    bus.m_ready = 0;
    check("st_beats", beats, 4);
    check("st_busy_fall", bus.busy, 0);
    check("st_mvalid_fall", bus.m_valid, 0);

    // Lock: parallel writes during load of reg2
    bus.ld_start = 1; bus.st_sel = 4'd2; bus.ld_len = 7'd3;
    tick();
    bus.ld_start = 0;
    bus.wr_en = 1; bus.wr_sel = 4'd2; bus.wr_data = {N{8'hFF}}; bus.wr_len = 7'd5;
    bus.rd_en_b = 1; bus.rd_sel_b = 4'd2;
    tick();
    bus.wr_sel = 4'd7; bus.wr_data = {N{8'h77}}; bus.wr_len = 7'd7;
    check("lock_werr", bus.wr_err, 1);
    check("lock_rd_vld", bus.out_b_vld, 0);
    tick();
    bus.wr_en = 0;
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1; bus.s_data = 8'(8'h21 + i);
      tick();
    end
    bus.s_valid = 0;
    check("lock_busy_fall", bus.busy, 0);
    bus.rd_sel_a = 4'd2; bus.rd_sel_b = 4'd7;
    tick();
    ev = '0;
    ev[0] = 8'h21; ev[1] = 8'h22; ev[2] = 8'h23;
    check("lock_r2_data", bus.out_a, ev);
    check("lock_r2_len", bus.out_a_len, 3);
    check("lock_r2_vld", bus.out_a_vld, 1);
    check("lock_r7_data", bus.out_b, {N{8'h77}});
    check("lock_r7_len", bus.out_b_len, 7);
    check("lock_r7_vld", bus.out_b_vld, 1);
    check("lock_werr_sticky", bus.wr_err, 1);

    // Zero-length load completes without entering LOAD
    bus.ld_start = 1; bus.st_sel = 4'd8; bus.ld_len = 7'd0;
    tick();
    bus.ld_start = 0;
    check("z_busy", bus.busy, 0);
    bus.rd_sel_a = 4'd8;
    tick();
    check("z_len", bus.out_a_len, 0);
    check("z_vld", bus.out_a_vld, 1);

    // Oversized load length: 200 truncates to 72 on the 7-bit port, then saturates to 64
    bus.ld_start = 1; bus.st_sel = 4'd9; bus.ld_len = LEN_W'(200);
    tick();
    bus.ld_start = 0;
    beats = 0; cyc = 0;
    while (bus.busy && cyc < 200) begin
      bus.s_valid = 1; bus.s_data = 8'(beats);
      if (bus.s_ready) beats++;
      tick();
      cyc++;
    end
    bus.s_valid = 0;
    check("big_beats", beats, N);
    check("big_busy", bus.busy, 0);
    bus.rd_sel_a = 4'd9;
    tick();
    for (int i = 0; i < N; i++) ev[i] = 8'(i);
    check("big_len", bus.out_a_len, N);
    check("big_data", bus.out_a, ev);
    check("big_elem63", bus.out_a[63], 63);

    // ld_start and st_start together: only the load runs
    bus.ld_start = 1; bus.st_start = 1; bus.st_sel = 4'd10; bus.ld_len = 7'd2;
    tick();
    bus.ld_start = 0; bus.st_start = 0;
    check("both_sready", bus.s_ready, 1);
    check("both_mvalid", bus.m_valid, 0);
    for (int i = 0; i < 2; i++) begin
      bus.s_valid = 1; bus.s_data = 8'(8'h31 + i);
      tick();
      check("both_mvalid_ld", bus.m_valid, 0);
    end
    bus.s_valid = 0;
    check("both_busy", bus.busy, 0);
    bus.rd_sel_b = 4'd10;
    tick();
    check("both_len", bus.out_b_len, 2);
    check("both_vld", bus.out_b_vld, 1);

    // Async reset in the middle of a store
    bus.st_start = 1; bus.st_sel = 4'd9;
    tick();
    bus.st_start = 0;
    check("rs_mvalid_pre", bus.m_valid, 1);
    check("rs_outa_vld_pre", bus.out_a_vld, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_busy", bus.busy, 0);
    check("rs_mvalid", bus.m_valid, 0);
    check("rs_mlast", bus.m_last, 0);
    check("rs_werr", bus.wr_err, 0);
    check("rs_outa", bus.out_a, 0);
    check("rs_outa_len", bus.out_a_len, 0);
    check("rs_outa_vld", bus.out_a_vld, 0);
    check("rs_outb_vld", bus.out_b_vld, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rs_r9_len", bus.out_a_len, 0);
    check("rs_r9_vld", bus.out_a_vld, 0);
    check("rs_r9_data", bus.out_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
